// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer
// Description : Multi-cycle fetch/decode/execute control unit for the
//               simple-viii datapath, with flag branches, an immediate
//               fetch, HALT and a memory-handshake timeout fault.
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_sequencer #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int REG_COUNT      = 4,
    parameter int MEM_TIMEOUT    = 15,
    localparam int REG_SEL_W     = $clog2(REG_COUNT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    input  logic                      mem_op_done,
    input  logic                      flag_zero_in,
    input  logic                      flag_carry_in,
    output logic [1:0]                mem_op,
    output logic [1:0]                addr_op,
    output logic                      addr_sel,
    output logic [2:0]                alu_op,
    output logic                      reg_we,
    output logic [REG_SEL_W-1:0]      reg_sel_in,
    output logic [REG_SEL_W-1:0]      reg_sel_1,
    output logic [REG_SEL_W-1:0]      reg_sel_2,
    output logic                      mux_sel,
    output logic                      halted,
    output logic                      fault
);

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] c_mem_idle  = 2'd0;
    localparam logic [1:0] c_mem_read  = 2'd1;
    localparam logic [1:0] c_mem_write = 2'd2;

    localparam logic [1:0] c_addr_pc_inc   = 2'd1;
    localparam logic [1:0] c_addr_pc_load  = 2'd2;
    localparam logic [1:0] c_addr_mar_load = 2'd3;

    localparam logic [3:0] c_op_nop  = 4'h0;
    localparam logic [3:0] c_op_xor  = 4'h5;
    localparam logic [3:0] c_op_ldi  = 4'h6;
    localparam logic [3:0] c_op_ld   = 4'h7;
    localparam logic [3:0] c_op_st   = 4'h8;
    localparam logic [3:0] c_op_jmp  = 4'h9;
    localparam logic [3:0] c_op_jz   = 4'hA;
    localparam logic [3:0] c_op_jc   = 4'hB;
    localparam logic [3:0] c_op_halt = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_IMM    = 3'd3,
        S_MADDR  = 3'd4,
        S_MACC   = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0] ir_q, ir_d;
    logic                      z_q, z_d;
    logic                      c_q, c_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;

    logic [3:0]           w_op;
    logic [REG_SEL_W-1:0] w_rd;
    logic [REG_SEL_W-1:0] w_rs;
    logic                 w_waiting;

    assign w_op = ir_q[DATA_BUS_WIDTH-1 -: 4];
    assign w_rd = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
    assign w_rs = ir_q[REG_SEL_W-1:0];

    assign w_waiting = (state_q == S_FETCH) || (state_q == S_IMM) || (state_q == S_MACC);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        z_d        = z_q;
        c_d        = c_q;
        tmo_d      = '0;
        mem_op     = c_mem_idle;
        addr_op    = 2'd0;
        addr_sel   = 1'b0;
        alu_op     = 3'd0;
        reg_we     = 1'b0;
        reg_sel_in = '0;
        reg_sel_1  = '0;
        reg_sel_2  = '0;
        mux_sel    = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_op = c_mem_read;
                if (mem_op_done) begin
                    ir_d    = bus_data_in;
                    addr_op = c_addr_pc_inc;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_op == c_op_nop) begin
                    state_d = S_FETCH;
                end else if (w_op <= c_op_xor) begin
                    state_d = S_EXEC;
                end else if ((w_op == c_op_ldi) || (w_op == c_op_jmp) ||
                             (w_op == c_op_jz)  || (w_op == c_op_jc)) begin
                    state_d = S_IMM;
                end else if ((w_op == c_op_ld) || (w_op == c_op_st)) begin
                    state_d = S_MADDR;
                end else if (w_op == c_op_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                alu_op     = 3'(w_op - 4'd1);
                reg_sel_1  = w_rd;
                reg_sel_2  = w_rs;
                reg_we     = 1'b1;
                reg_sel_in = w_rd;
                z_d        = flag_zero_in;
                c_d        = flag_carry_in;
                state_d    = S_FETCH;
            end
            S_IMM: begin
                mem_op = c_mem_read;
                if (mem_op_done) begin
                    state_d = S_FETCH;
                    case (w_op)
                        c_op_ldi: begin
                            reg_we     = 1'b1;
                            mux_sel    = 1'b1;
                            reg_sel_in = w_rd;
                            addr_op    = c_addr_pc_inc;
                        end
                        c_op_jmp: addr_op = c_addr_pc_load;
                        c_op_jz:  addr_op = z_q ? c_addr_pc_load : c_addr_pc_inc;
                        default:  addr_op = c_q ? c_addr_pc_load : c_addr_pc_inc;
                    endcase
                end
            end
            S_MADDR: begin
                addr_op   = c_addr_mar_load;
                reg_sel_1 = (w_op == c_op_ld) ? w_rs : w_rd;
                state_d   = S_MACC;
            end
            S_MACC: begin
                addr_sel = 1'b1;
                if (w_op == c_op_ld) begin
                    mem_op = c_mem_read;
                    if (mem_op_done) begin
                        reg_we     = 1'b1;
                        mux_sel    = 1'b1;
                        reg_sel_in = w_rd;
                    end
                end else begin
                    mem_op    = c_mem_write;
                    reg_sel_2 = w_rs;
                end
                if (mem_op_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  halted = 1'b1;
            default: fault  = 1'b1;
        endcase

        // Counter restarts at zero on every entry because it defaults to zero
        // whenever the core is not stalled on the memory handshake.
        if (w_waiting && !mem_op_done) begin
            if (tmo_q == c_tmo_last) begin
                state_d = S_FAULT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (reset) begin
            mem_op     = c_mem_idle;
            addr_op    = 2'd0;
            addr_sel   = 1'b0;
            alu_op     = 3'd0;
            reg_we     = 1'b0;
            reg_sel_in = '0;
            reg_sel_1  = '0;
            reg_sel_2  = '0;
            mux_sel    = 1'b0;
            halted     = 1'b0;
            fault      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
`default_nettype wire
